// File: rtl/csa_mul_pkg.sv
// Shared definitions for the CSA sequential multiplier.
// Contents:
//   state_e       FSM state encoding (idle / compress / final resolve / result held)
//   steps()       number of compress cycles for a given width and partial products per cycle
//   step_width()  width of the compress step counter (at least 1 bit)
package csa_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCompress,
    StFinal,
    StDone
  } state_e;

  function automatic int unsigned steps(input int unsigned w, input int unsigned p);
    return w / p;
  endfunction

  function automatic int unsigned step_width(input int unsigned s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational 3:2 carry-save row.
// Ports:
//   x_i, y_i, z_i  three N-bit addends
//   s_o            bitwise sum (x ^ y ^ z)
//   c_o            majority carry shifted left by one; the bit shifted out of N is dropped
module csa_row #(
  parameter int unsigned N = 64
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] z_i,
  output logic [N-1:0] s_o,
  output logic [N-1:0] c_o
);

  always_comb begin
    s_o = x_i ^ y_i ^ z_i;
    c_o = ((x_i & y_i) | (x_i & z_i) | (y_i & z_i)) << 1;
  end

endmodule

// File: rtl/csa_seq_multiplier.sv
// Multi-cycle carry-save multiplier functional unit.
// Each COMPRESS cycle folds PP_PER_CYCLE partial products into a redundant sum/carry pair with
// a chain of csa_row instances; one FINAL cycle resolves the pair with a carry-propagate add.
// The product is returned with its reservation-station tag over a valid/ready handshake.
// Optional feature: define SIGNED_MUL_EN to add the in_signed port (two's-complement operands).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only when idle
//   in_a, in_b, in_tag  multiplicand, multiplier, destination tag
//   in_signed           operands are signed (SIGNED_MUL_EN only)
//   flush               synchronous squash of any in-flight operation
//   out_valid/out_ready result handshake toward the CDB arbiter
//   out_prod, out_tag   2*WIDTH-bit product and its tag
module csa_seq_multiplier
  import csa_mul_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned PP_PER_CYCLE = 4,
  parameter int unsigned TAG_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_W-1:0]     in_tag,
`ifdef SIGNED_MUL_EN
  input  logic                 in_signed,
`endif
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned STEPS = steps(WIDTH, PP_PER_CYCLE);
  localparam int unsigned SW    = step_width(STEPS);
  localparam logic [SW-1:0] StepLast = SW'(STEPS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [PW-1:0]      sum_q, sum_d;
  logic [PW-1:0]      carry_q, carry_d;
  logic [SW-1:0]      step_q, step_d;
  logic [PW-1:0]      out_prod_q, out_prod_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;
  logic               out_valid_q, out_valid_d;
`ifdef SIGNED_MUL_EN
  logic               neg_q, neg_d;
`endif

  logic               accept;
  logic [31:0]        shamt;
  logic [PP_PER_CYCLE-1:0] b_win;
  logic [PW-1:0]      a_win;
  logic [PW-1:0]      pp [PP_PER_CYCLE];
  logic [PW-1:0]      s_chain [PP_PER_CYCLE+1];
  logic [PW-1:0]      c_chain [PP_PER_CYCLE+1];
  logic [PW-1:0]      resolved;

  assign accept = (state_q == StIdle) && in_valid && !flush;

  // Partial products for the current step: bits [k*P +: P] of b select shifted copies of a.
  always_comb begin
    shamt = 32'(step_q) * PP_PER_CYCLE;
    b_win = PP_PER_CYCLE'(b_q >> shamt);
    a_win = {{WIDTH{1'b0}}, a_q} << shamt;
    for (int j = 0; j < int'(PP_PER_CYCLE); j++) begin
      pp[j] = b_win[j] ? (a_win << j) : '0;
    end
  end

  assign s_chain[0] = sum_q;
  assign c_chain[0] = carry_q;

  for (genvar g = 0; g < int'(PP_PER_CYCLE); g++) begin : g_rows
    csa_row #(
      .N(PW)
    ) u_row (
      .x_i(s_chain[g]),
      .y_i(c_chain[g]),
      .z_i(pp[g]),
      .s_o(s_chain[g+1]),
      .c_o(c_chain[g+1])
    );
  end

  assign resolved = sum_q + carry_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     if (in_valid) state_d = StCompress;
        StCompress: if (step_q == StepLast) state_d = StFinal;
        StFinal:    state_d = StDone;
        StDone:     if (out_ready) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    step_d      = step_q;
    out_prod_d  = out_prod_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
`ifdef SIGNED_MUL_EN
    neg_d       = neg_q;
`endif

    if (accept) begin
`ifdef SIGNED_MUL_EN
      // Magnitudes are unsigned W-bit values, so |MIN_INT| = 2^(W-1) fits.
      a_d   = (in_signed && in_a[WIDTH-1]) ? (~in_a + 1'b1) : in_a;
      b_d   = (in_signed && in_b[WIDTH-1]) ? (~in_b + 1'b1) : in_b;
      neg_d = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
`else
      a_d   = in_a;
      b_d   = in_b;
`endif
      tag_d   = in_tag;
      sum_d   = '0;
      carry_d = '0;
      step_d  = '0;
    end

    if (state_q == StCompress) begin
      sum_d   = s_chain[PP_PER_CYCLE];
      carry_d = c_chain[PP_PER_CYCLE];
      step_d  = step_q + 1'b1;
    end

    if (state_q == StFinal) begin
`ifdef SIGNED_MUL_EN
      out_prod_d = neg_q ? (~resolved + 1'b1) : resolved;
`else
      out_prod_d = resolved;
`endif
      out_tag_d   = tag_q;
      out_valid_d = 1'b1;
    end

    if (state_q == StDone && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      sum_q       <= '0;
      carry_q     <= '0;
      step_q      <= '0;
      out_prod_q  <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef SIGNED_MUL_EN
      neg_q       <= 1'b0;
`endif
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      step_q      <= step_d;
      out_prod_q  <= out_prod_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
`ifdef SIGNED_MUL_EN
      neg_q       <= neg_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = out_valid_q;
    out_prod  = out_prod_q;
    out_tag   = out_tag_q;
  end

endmodule

// File: tb/tb_csa_seq_multiplier.sv
// Scoreboard bench for csa_seq_multiplier: stimulus pushes expected results into a queue and a
// monitor pops and compares on every output handshake.
module tb_csa_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
`ifdef SIGNED_MUL_EN
  logic        in_signed;
`endif
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;
  logic [3:0]  out_tag;

  typedef struct {
    logic [63:0] prod;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  csa_seq_multiplier #(
    .WIDTH(32),
    .PP_PER_CYCLE(4),
    .TAG_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a(in_a),
    .in_b(in_b),
    .in_tag(in_tag),
`ifdef SIGNED_MUL_EN
    .in_signed(in_signed),
`endif
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_prod(out_prod),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare on each output handshake, sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got prod=%h tag=%0d, required no output",
                   out_prod, out_tag);
        end else begin
          e = sb_q.pop_front();
          if (out_prod !== e.prod || out_tag !== e.tag) begin
            errors++;
            $display("FAIL result: got prod=%h tag=%0d, required prod=%h tag=%0d",
                     out_prod, out_tag, e.prod, e.tag);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Issue one op; returns #1 after the edge where out_valid rose (or after the bound expires).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic sgn, input logic [63:0] prod, input logic expect_out);
    int lat;
    lat = 0;
    while (!in_ready && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("in_ready_before_issue", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
`ifdef SIGNED_MUL_EN
    in_signed = sgn;
`else
    if (sgn) $display("note: signed op requested without SIGNED_MUL_EN");
`endif
    if (expect_out) sb_q.push_back('{prod: prod, tag: tag});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (expect_out) begin
      lat = 0;
      while (!out_valid && lat < 30) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("latency", 64'(lat), 64'd9);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
`ifdef SIGNED_MUL_EN
    in_signed = 1'b0;
`endif
    cycles(2);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_prod", out_prod, 64'd0);
    check("reset_out_tag", {60'd0, out_tag}, 64'd0);
    rst_n = 1'b1;
    cycles(2);

    // 1. all-ones operands
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1);
    cycles(1);
    // 2. zero and single-bit operands still take the full latency
    issue(32'h0, 32'h1234_5678, 4'd1, 1'b0, 64'h0, 1'b1);
    cycles(1);
    issue(32'h1, 32'h8000_0000, 4'd2, 1'b0, 64'h0000_0000_8000_0000, 1'b1);
    cycles(1);
    issue(32'h1234_5678, 32'h10, 4'd3, 1'b0, 64'h0000_0001_2345_6780, 1'b1);
    cycles(1);

    // 3. back-pressure: result held stable, no new acceptance
    out_ready = 1'b0;
    issue(32'hDEAD_BEEF, 32'h2, 4'd9, 1'b0, 64'h0000_0001_BD5B_7DDE, 1'b1);
    for (int i = 0; i < 20; i++) begin
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_out_prod", out_prod, 64'h0000_0001_BD5B_7DDE);
      check("hold_out_tag", {60'd0, out_tag}, 64'd9);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      cycles(1);
    end
    out_ready = 1'b1;
    cycles(1);
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    check("release_out_valid", {63'd0, out_valid}, 64'd0);

    // 4. flush at compress step 3
    issue(32'hFFFF_FFFF, 32'h1234_5678, 4'd7, 1'b0, 64'h0, 1'b0);
    cycles(3);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      cycles(1);
    end
    check("flush_no_output", 64'(seen), 64'd0);
    issue(32'd3, 32'd7, 4'd4, 1'b0, 64'd21, 1'b1);
    cycles(1);

    // flush beats a same-cycle in_valid
    in_valid = 1'b1;
    in_a     = 32'd5;
    in_b     = 32'd5;
    flush    = 1'b1;
    cycles(1);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_vs_accept_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      cycles(1);
    end
    check("flush_vs_accept_no_output", 64'(seen), 64'd0);

    // 5. asynchronous reset mid-operation at step 5
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 1'b0, 64'h0, 1'b0);
    cycles(5);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    check("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    check("midreset_out_prod", out_prod, 64'd0);
    check("midreset_out_tag", {60'd0, out_tag}, 64'd0);
    cycles(2);
    check("midreset_hold_out_valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;
    cycles(1);
    issue(32'h0001_0000, 32'h0001_0000, 4'd8, 1'b0, 64'h0000_0001_0000_0000, 1'b1);
    cycles(1);

`ifdef SIGNED_MUL_EN
    // 6. signed operands
    issue(32'hFFFF_FFFD, 32'd5, 4'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    cycles(1);
    issue(32'h8000_0000, 32'h8000_0000, 4'd11, 1'b1, 64'h4000_0000_0000_0000, 1'b1);
    cycles(1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd12, 1'b1, 64'h0000_0000_0000_0001, 1'b1);
    cycles(1);
`endif

    cycles(3);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
